// File: rtl/iob_ram_tiled_bist.sv
// ---------------------------------------------------------------------------
// iob_ram_tiled_bist
//
// March-style built-in self test for a single-port synchronous RAM.
// One run covers all N = 2**ADDR_W words in three phases:
//   WR0      : ascending, write PATTERN to every word.
//   RD1 pair : ascending, read and expect PATTERN, then write ~PATTERN to
//              the same word in the following cycle.
//   RD2 pair : descending, read and expect ~PATTERN (no write).
// A run therefore occupies 5N busy cycles, followed by a one-cycle done pulse.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   synchronous, active-high reset (wins over start)
//   start      in   one-cycle run request, honoured only in IDLE
//   w_en       out  RAM write enable
//   r_en       out  RAM read enable (never together with w_en)
//   addr       out  RAM shared read/write address
//   w_data     out  RAM write data
//   r_data     in   RAM read data, valid the cycle after an r_en cycle
//   busy       out  high for the 5N cycles of a run
//   done       out  one-cycle pulse right after the last compare
//   pass       out  result of the last completed run (no mismatches)
//   err_cnt    out  saturating mismatch count for the current/last run
//   fail_addr  out  address of the first mismatch of the current/last run
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module iob_ram_tiled_bist #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 13,
  // Alternating 1010... background with the MSB set, for any DATA_W.
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'({DATA_W{2'b10}} >> (DATA_W % 2)),
  parameter int unsigned       ERR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              w_en,
  output logic              r_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR0     = 3'd1,
    RD1_REQ = 3'd2,
    RD1_CHK = 3'd3,
    RD2_REQ = 3'd4,
    RD2_CHK = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_t              state_q, state_d;
  logic                w_en_q, w_en_d;
  logic                r_en_q, r_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fail_q, fail_d;
  logic                mismatch;

  // Next-state logic. The RAM-side controls are computed one cycle ahead so
  // that the registered outputs line up with the state the FSM enters.
  always_comb begin
    state_d  = state_q;
    w_en_d   = 1'b0;
    r_en_d   = 1'b0;
    addr_d   = addr_q;
    w_data_d = w_data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WR0;
          w_en_d   = 1'b1;
          addr_d   = '0;
          w_data_d = PATTERN;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          fail_d   = '0;
        end
      end

      WR0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = RD1_REQ;
          r_en_d  = 1'b1;
          addr_d  = '0;
        end else begin
          w_en_d = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end

      // The read-back write goes out in the check cycle at the same address.
      RD1_REQ: begin
        state_d  = RD1_CHK;
        w_en_d   = 1'b1;
        w_data_d = ~PATTERN;
      end

      RD1_CHK: begin
        mismatch = (r_data != PATTERN);
        r_en_d   = 1'b1;
        if (addr_q == ADDR_LAST) begin
          // Phase 3 starts at the top address, so addr is left as is.
          state_d = RD2_REQ;
        end else begin
          state_d = RD1_REQ;
          addr_d  = addr_q + 1'b1;
        end
      end

      RD2_REQ: begin
        state_d = RD2_CHK;
      end

      RD2_CHK: begin
        mismatch = (r_data != ~PATTERN);
        if (addr_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Include the compare happening in this very cycle.
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          state_d = RD2_REQ;
          r_en_d  = 1'b1;
          addr_d  = addr_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // err_q is still zero exactly when this is the first mismatch of the
    // run, since the counter saturates instead of wrapping back to zero.
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        fail_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
      addr_q   <= '0;
      w_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign w_en      = w_en_q;
  assign r_en      = r_en_q;
  assign addr      = addr_q;
  assign w_data    = w_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_iob_ram_tiled_bist.sv
// ---------------------------------------------------------------------------
// Testbench for iob_ram_tiled_bist (ADDR_W=4, DATA_W=32).
// A behavioural RAM with selectable faults sits behind the main instance; a
// second instance with ERR_W=2 sees an all-zero read bus.
// Expected per-cycle RAM traffic and end-of-run results are queued when a run
// is launched and consumed by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_iob_ram_tiled_bist;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 4;
  localparam int          N   = 16;
  localparam logic [DW-1:0] PAT = 32'hAAAA_AAAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start2;
  logic          w_en, r_en, busy, done, pass;
  logic [AW-1:0] addr, fail_addr;
  logic [DW-1:0] w_data, r_data;
  logic [15:0]   err_cnt;

  logic          s_w_en, s_r_en, s_busy, s_done, s_pass;
  logic [AW-1:0] s_addr, s_fail_addr;
  logic [DW-1:0] s_w_data;
  logic [1:0]    s_err_cnt;
  logic [DW-1:0] zero_data;
  assign zero_data = '0;

  iob_ram_tiled_bist #(.DATA_W(32), .ADDR_W(4), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .w_en(w_en), .r_en(r_en), .addr(addr), .w_data(w_data), .r_data(r_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
  );

  iob_ram_tiled_bist #(.DATA_W(32), .ADDR_W(4), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start2),
    .w_en(s_w_en), .r_en(s_r_en), .addr(s_addr), .w_data(s_w_data), .r_data(zero_data),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt), .fail_addr(s_fail_addr)
  );

  // RAM model. fault_mode: 0 none, 1 bit0 stuck-at-1 @5,
  // 2 writes to 3 dropped, 3 bit0 stuck-at-1 @5 and @9.
  int unsigned   fault_mode;
  logic [DW-1:0] mem [N];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      r_data <= '0;
    end else begin
      if (w_en && !(fault_mode == 2 && addr == 4'd3)) mem[addr] <= w_data;
      if (r_en) begin
        if ((fault_mode == 1 && addr == 4'd5) ||
            (fault_mode == 3 && (addr == 4'd5 || addr == 4'd9)))
          r_data <= mem[addr] | 32'd1;
        else
          r_data <= mem[addr];
      end
    end
  end

  typedef struct {
    logic          w_en;
    logic          r_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          done;
  } trace_t;

  typedef struct {
    logic [15:0]   err;
    logic [AW-1:0] fail;
    logic          pass;
  } result_t;

  trace_t  trace_q[$];
  result_t res_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;

  function automatic trace_t mk(logic we, logic re, int a, logic [DW-1:0] wd,
                                logic b, logic d);
    trace_t t;
    t.w_en = we; t.r_en = re; t.addr = AW'(a); t.w_data = wd; t.busy = b; t.done = d;
    return t;
  endfunction

  // Pulse start, then queue the expected traffic for cycles 1..5N+2 and the
  // expected end-of-run result. Returns #1 into run cycle 1.
  task automatic launch_run(input logic [15:0] e_err, input logic [AW-1:0] e_fail,
                            input logic e_pass);
    result_t r;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int a = 0; a < N; a++) trace_q.push_back(mk(1, 0, a, PAT, 1, 0));
    for (int a = 0; a < N; a++) begin
      trace_q.push_back(mk(0, 1, a, '0, 1, 0));
      trace_q.push_back(mk(1, 0, a, ~PAT, 1, 0));
    end
    for (int a = N - 1; a >= 0; a--) begin
      trace_q.push_back(mk(0, 1, a, '0, 1, 0));
      trace_q.push_back(mk(0, 0, a, '0, 1, 0));
    end
    trace_q.push_back(mk(0, 0, 0, '0, 0, 1));
    trace_q.push_back(mk(0, 0, 0, '0, 0, 0));
    r.err = e_err; r.fail = e_fail; r.pass = e_pass;
    res_q.push_back(r);
  endtask

  task automatic wait_drain(input string tag);
    int i = 0;
    while ((trace_q.size() != 0 || res_q.size() != 0) && i < 300) begin
      @(posedge clk); i++;
    end
    #1;
    n_checks++;
    if (trace_q.size() != 0 || res_q.size() != 0) begin
      $display("FAIL %s drain: %0d trace and %0d result entries pending, want 0",
               tag, trace_q.size(), res_q.size());
      trace_q.delete(); res_q.delete();
    end else n_pass++;
  endtask

  trace_t  mon_e;
  result_t mon_r;

  always @(negedge clk) begin
    if (trace_q.size() != 0) begin
      mon_e = trace_q.pop_front();
      n_checks++;
      if (w_en !== mon_e.w_en || r_en !== mon_e.r_en || busy !== mon_e.busy ||
          done !== mon_e.done ||
          ((mon_e.w_en || mon_e.r_en) && addr !== mon_e.addr) ||
          (mon_e.w_en && w_data !== mon_e.w_data))
        $display("FAIL trace @%0t: w_en=%0b r_en=%0b addr=%0d w_data=%h busy=%0b done=%0b, want %0b %0b %0d %h %0b %0b",
                 $time, w_en, r_en, addr, w_data, busy, done,
                 mon_e.w_en, mon_e.r_en, mon_e.addr, mon_e.w_data, mon_e.busy, mon_e.done);
      else n_pass++;
    end
    if (done === 1'b1) begin
      n_checks++;
      if (res_q.size() == 0)
        $display("FAIL unexpected_done @%0t: done=1, want 0", $time);
      else begin
        mon_r = res_q.pop_front();
        if (err_cnt !== mon_r.err || fail_addr !== mon_r.fail || pass !== mon_r.pass)
          $display("FAIL result: err_cnt=%0d fail_addr=%0d pass=%0b, want %0d %0d %0b",
                   err_cnt, fail_addr, pass, mon_r.err, mon_r.fail, mon_r.pass);
        else n_pass++;
      end
    end
    if (busy === 1'b1) begin
      n_checks++;
      assert (!(w_en === 1'b1 && r_en === 1'b1)) n_pass++;
      else $display("FAIL exclusive @%0t: w_en=%0b r_en=%0b, want not both 1", $time, w_en, r_en);
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start2 = 1'b1; fault_mode = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({w_en, r_en, busy, done, pass} !== 5'b0)
      $display("FAIL reset_flags: w_en/r_en/busy/done/pass=%b, want 00000", {w_en, r_en, busy, done, pass});
    else n_pass++;
    n_checks++;
    if (addr !== '0 || w_data !== '0)
      $display("FAIL reset_bus: addr=%0d w_data=%h, want 0 0", addr, w_data);
    else n_pass++;
    n_checks++;
    if (err_cnt !== '0 || fail_addr !== '0)
      $display("FAIL reset_err: err_cnt=%0d fail_addr=%0d, want 0 0", err_cnt, fail_addr);
    else n_pass++;
    n_checks++;
    if (s_busy !== 1'b0 || s_err_cnt !== '0)
      $display("FAIL reset_sat: busy=%0b err_cnt=%0d, want 0 0", s_busy, s_err_cnt);
    else n_pass++;
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_fault_free();
    fault_mode = 0;
    launch_run(16'd0, 4'd0, 1'b1);
    wait_drain("fault_free");
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (pass !== 1'b1 || err_cnt !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL fault_free_hold: pass=%0b err_cnt=%0d busy=%0b done=%0b, want 1 0 0 0",
               pass, err_cnt, busy, done);
    else n_pass++;
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    launch_run(16'd1, 4'd5, 1'b0);
    wait_drain("stuck_bit");
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (pass !== 1'b0 || err_cnt !== 16'd1 || fail_addr !== 4'd5)
      $display("FAIL stuck_hold: pass=%0b err_cnt=%0d fail_addr=%0d, want 0 1 5",
               pass, err_cnt, fail_addr);
    else n_pass++;
  endtask

  task automatic test_write_ignored();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fault_mode = 2;
    launch_run(16'd2, 4'd3, 1'b0);
    wait_drain("write_ignored");
  endtask

  task automatic test_first_fail_kept();
    fault_mode = 3;
    launch_run(16'd2, 4'd5, 1'b0);
    wait_drain("first_fail_kept");
  endtask

  task automatic test_err_saturate();
    int cyc;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 1;
    while (s_done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (cyc != 81) $display("FAIL sat_done_cycle: done at cycle %0d, want 81", cyc);
    else n_pass++;
    n_checks++;
    if (s_err_cnt !== 2'd3 || s_fail_addr !== 4'd0 || s_pass !== 1'b0)
      $display("FAIL sat_result: err_cnt=%0d fail_addr=%0d pass=%0b, want 3 0 0",
               s_err_cnt, s_fail_addr, s_pass);
    else n_pass++;
  endtask

  task automatic test_abort();
    int bad = 0;
    fault_mode = 0;
    launch_run(16'd0, 4'd0, 1'b1);
    repeat (39) @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    trace_q.delete(); res_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if ({w_en, r_en, busy, done, pass} !== 5'b0 || addr !== '0 || w_data !== '0 ||
        err_cnt !== '0 || fail_addr !== '0)
      $display("FAIL abort_reset: w_en=%0b r_en=%0b busy=%0b done=%0b pass=%0b addr=%0d w_data=%h err=%0d fail=%0d, want all 0",
               w_en, r_en, busy, done, pass, addr, w_data, err_cnt, fail_addr);
    else n_pass++;
    for (int i = 0; i < 90; i++) begin
      if (done !== 1'b0 || w_en !== 1'b0 || r_en !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_quiet: %0d active cycles after abort, want 0", bad);
    else n_pass++;
    launch_run(16'd0, 4'd0, 1'b1);
    wait_drain("after_abort");
  endtask

  task automatic test_start_ignored();
    fault_mode = 0;
    launch_run(16'd0, 4'd0, 1'b1);
    repeat (9) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (70) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain("start_ignored");
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || w_en !== 1'b0 || pass !== 1'b1)
      $display("FAIL start_in_done: busy=%0b w_en=%0b pass=%0b, want 0 0 1", busy, w_en, pass);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_write_ignored();
    test_first_fail_kept();
    test_start_ignored();
    test_err_saturate();
    test_abort();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
